// File: rtl/acc_alu_n_if.sv
// Command/result bundle for the acc_alu_n accumulator ALU.
// master drives operands and commands; slave (the ALU) returns the accumulator and status.
`timescale 1ns/1ps
interface acc_alu_n_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] BusOut;
    logic             Wen;
    logic             INC;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] dout;
    logic             Z;
    logic             N;
    logic             C;
    logic             V;
    logic             busy;
    logic             done;

    modport master (
        output BusOut, Wen, INC, alu_op,
        input  dout, Z, N, C, V, busy, done
    );

    modport slave (
        input  BusOut, Wen, INC, alu_op,
        output dout, Z, N, C, V, busy, done
    );
endinterface

// File: rtl/acc_alu_n.sv
// Accumulator ALU with single-cycle ops, multi-cycle barrel-free shifts and an optional
// shift-add multiplier (op 9), which is only built when ACC_ALU_N_MUL_EN is defined.
`timescale 1ns/1ps
module acc_alu_n #(
    parameter int WIDTH = 8
) (
    input logic        Clk,
    input logic        RST,
    acc_alu_n_if.slave bus
);
    localparam int               CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]    CNT_MAX = CW'(WIDTH);
    localparam logic [WIDTH-1:0] WIDTH_W = WIDTH'(WIDTH);
    localparam int               M       = WIDTH - 1;

    localparam logic [3:0] OP_PASS = 4'd0;
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_NOT  = 4'd6;
    localparam logic [3:0] OP_SHL1 = 4'd7;
    localparam logic [3:0] OP_SHR1 = 4'd8;
`ifdef ACC_ALU_N_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd9;
`endif
    localparam logic [3:0] OP_SHLN = 4'd10;
    localparam logic [3:0] OP_SHRN = 4'd11;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
    typedef enum logic [1:0] {M_SHL, M_SHR, M_MUL} mop_t;

    state_t           state_q, state_d;
    mop_t             mop_q, mop_d;
    logic [WIDTH-1:0] ac_q, ac_d;
    logic             z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sh_q, sh_d;
`ifdef ACC_ALU_N_MUL_EN
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [2*WIDTH-1:0] prod_next;
`endif

    logic [WIDTH:0]   add_r, sub_r, inc_r;
    logic [WIDTH-1:0] sh_next;
    logic             sh_bit;
    logic [CW-1:0]    shift_n;
    logic             wr;
    logic [WIDTH-1:0] res;
    logic             cf, vf;

    assign add_r   = {1'b0, ac_q} + {1'b0, bus.BusOut};
    assign sub_r   = {1'b0, ac_q} - {1'b0, bus.BusOut};
    assign inc_r   = {1'b0, ac_q} + (WIDTH + 1)'(1);
    assign shift_n = (bus.BusOut >= WIDTH_W) ? CNT_MAX : bus.BusOut[CW-1:0];

    always_comb begin
        state_d = state_q;
        mop_d   = mop_q;
        ac_d    = ac_q;
        z_d     = z_q;
        n_d     = n_q;
        c_d     = c_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
`ifdef ACC_ALU_N_MUL_EN
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        prod_d    = prod_q;
        prod_next = prod_q + (mplier_q[0] ? mcand_q : '0);
`endif
        wr      = 1'b0;
        res     = ac_q;
        cf      = 1'b0;
        vf      = 1'b0;
        sh_next = (mop_q == M_SHR) ? {1'b0, sh_q[M:1]} : {sh_q[M-1:0], 1'b0};
        sh_bit  = (mop_q == M_SHR) ? sh_q[0] : sh_q[M];

        case (state_q)
            S_EXEC: begin
                // Work happens in shadow registers; AC is only written on the final step.
                cnt_d = cnt_q - 1'b1;
`ifdef ACC_ALU_N_MUL_EN
                if (mop_q == M_MUL) begin
                    prod_d   = prod_next;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    if (cnt_q == CW'(1)) begin
                        wr      = 1'b1;
                        res     = prod_next[WIDTH-1:0];
                        cf      = |prod_next[2*WIDTH-1:WIDTH];
                        state_d = S_DONE;
                    end
                end else
`endif
                begin
                    sh_d = sh_next;
                    if (cnt_q == CW'(1)) begin
                        wr      = 1'b1;
                        res     = sh_next;
                        cf      = sh_bit;
                        state_d = S_DONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                if (bus.Wen) begin
                    case (bus.alu_op)
                        OP_PASS: begin wr = 1'b1; res = bus.BusOut; end
                        OP_ADD: begin
                            wr  = 1'b1;
                            res = add_r[M:0];
                            cf  = add_r[WIDTH];
                            vf  = (ac_q[M] == bus.BusOut[M]) && (add_r[M] != ac_q[M]);
                        end
                        OP_SUB: begin
                            wr  = 1'b1;
                            res = sub_r[M:0];
                            cf  = sub_r[WIDTH];
                            vf  = (ac_q[M] != bus.BusOut[M]) && (sub_r[M] != ac_q[M]);
                        end
                        OP_AND:  begin wr = 1'b1; res = ac_q & bus.BusOut; end
                        OP_OR:   begin wr = 1'b1; res = ac_q | bus.BusOut; end
                        OP_XOR:  begin wr = 1'b1; res = ac_q ^ bus.BusOut; end
                        OP_NOT:  begin wr = 1'b1; res = ~ac_q; end
                        OP_SHL1: begin wr = 1'b1; res = {ac_q[M-1:0], 1'b0}; cf = ac_q[M]; end
                        OP_SHR1: begin wr = 1'b1; res = {1'b0, ac_q[M:1]}; cf = ac_q[0]; end
`ifdef ACC_ALU_N_MUL_EN
                        OP_MUL: begin
                            mop_d    = M_MUL;
                            cnt_d    = CNT_MAX;
                            mcand_d  = {{WIDTH{1'b0}}, ac_q};
                            mplier_d = bus.BusOut;
                            prod_d   = '0;
                            state_d  = S_EXEC;
                        end
`endif
                        OP_SHLN, OP_SHRN: begin
                            mop_d = (bus.alu_op == OP_SHRN) ? M_SHR : M_SHL;
                            sh_d  = ac_q;
                            cnt_d = shift_n;
                            // A zero count still completes through DONE, clearing C.
                            if (shift_n == '0) begin
                                wr      = 1'b1;
                                state_d = S_DONE;
                            end else begin
                                state_d = S_EXEC;
                            end
                        end
                        default: ;
                    endcase
                end else if (bus.INC) begin
                    wr  = 1'b1;
                    res = inc_r[M:0];
                    cf  = inc_r[WIDTH];
                    vf  = ~ac_q[M] & inc_r[M];
                end
            end
        endcase

        if (wr) begin
            ac_d = res;
            z_d  = (res == '0);
            n_d  = res[M];
            c_d  = cf;
            v_d  = vf;
        end
    end

    always_ff @(posedge Clk or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            mop_q   <= M_SHL;
            ac_q    <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
            c_q     <= 1'b0;
            v_q     <= 1'b0;
            cnt_q   <= '0;
            sh_q    <= '0;
`ifdef ACC_ALU_N_MUL_EN
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            mop_q   <= mop_d;
            ac_q    <= ac_d;
            z_q     <= z_d;
            n_q     <= n_d;
            c_q     <= c_d;
            v_q     <= v_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
`ifdef ACC_ALU_N_MUL_EN
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
`endif
        end
    end

    assign bus.dout = ac_q;
    assign bus.Z    = z_q;
    assign bus.N    = n_q;
    assign bus.C    = c_q;
    assign bus.V    = v_q;
    assign bus.busy = (state_q == S_EXEC);
    assign bus.done = (state_q == S_DONE);
endmodule

// File: tb/tb_acc_alu_n.sv
// Bench for acc_alu_n (WIDTH=8): vector table for single-cycle ops plus hand sequences
// for shifts, multiply (when ACC_ALU_N_MUL_EN is defined) and reset abort.
`timescale 1ns/1ps
module tb_acc_alu_n;
    localparam int W = 8;

    logic Clk;
    logic RST;

    acc_alu_n_if #(.WIDTH(W)) bus ();
    acc_alu_n #(.WIDTH(W)) dut (.Clk(Clk), .RST(RST), .bus(bus));

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       wen;
        logic       inc;
        logic [3:0] op;
        logic [7:0] b;
        logic [7:0] d;
        logic [3:0] f;   // {Z,N,C,V}
    } vec_t;

    typedef struct {
        string      name;
        logic [7:0] d;
        logic [3:0] f;
    } exp_t;

    exp_t sb[$];
    vec_t vt[25];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_pop();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        $display("txn %-16s dout=0x%02h ZNCV=%04b busy=%0b done=%0b", e.name, bus.dout,
                 {bus.Z, bus.N, bus.C, bus.V}, bus.busy, bus.done);
        chk({e.name, " dout"}, 32'(bus.dout), 32'(e.d));
        chk({e.name, " flags"}, 32'({bus.Z, bus.N, bus.C, bus.V}), 32'(e.f));
    endtask

    task automatic drive(input logic wen, input logic inc, input logic [3:0] op, input logic [7:0] b);
        bus.Wen    = wen;
        bus.INC    = inc;
        bus.alu_op = op;
        bus.BusOut = b;
    endtask

    task automatic idle();
        bus.Wen = 1'b0;
        bus.INC = 1'b0;
    endtask

    // Single-cycle command: result expected right after the sampling edge.
    task automatic apply(input logic wen, input logic inc, input logic [3:0] op, input logic [7:0] b,
                         input logic [7:0] d, input logic [3:0] f, input string name);
        sb.push_back('{name, d, f});
        drive(wen, inc, op, b);
        @(posedge Clk); #1;
        idle();
        sb_pop();
        chk({name, " busy"}, 32'(bus.busy), 32'd0);
    endtask

    // Multi-cycle command: counts busy cycles, checks dout holds, pops on done.
    task automatic run_multi(input logic [3:0] op, input logic [7:0] b, input int exp_cyc,
                             input logic [7:0] d, input logic [3:0] f, input bit inject,
                             input string name);
        logic [7:0] ac_before;
        int nb  = 0;
        bit got = 0;
        sb.push_back('{name, d, f});
        ac_before = bus.dout;
        drive(1'b1, 1'b0, op, b);
        @(posedge Clk); #1;
        if (inject) drive(1'b1, 1'b0, 4'd0, 8'h55);
        else        idle();
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                idle();
                got = 1;
                break;
            end
            if (bus.busy) begin
                nb++;
                chk({name, " dout_hold"}, 32'(bus.dout), 32'(ac_before));
            end
            @(posedge Clk); #1;
        end
        idle();
        chk({name, " busy_cycles"}, 32'(nb), 32'(exp_cyc));
        chk({name, " done_seen"}, 32'(got), 32'd1);
        if (got) sb_pop();
        else void'(sb.pop_front());
        @(posedge Clk); #1;
        chk({name, " done_pulse_end"}, 32'({bus.done, bus.busy}), 32'd0);
    endtask

    initial begin
        bit seen;
        RST = 1'b1;
        drive(1'b0, 1'b0, 4'd0, 8'd0);
        #1;
        chk("rst dout", 32'(bus.dout), 32'd0);
        chk("rst flags", 32'({bus.Z, bus.N, bus.C, bus.V}), 32'd0);
        chk("rst busy_done", 32'({bus.busy, bus.done}), 32'd0);
        #11 RST = 1'b0;
        @(posedge Clk); #1;

        //          wen   inc   op     b       d       ZNCV
        vt[0]  = '{1'b1, 1'b0, 4'd0,  8'd20,  8'd20,  4'b0000};
        vt[1]  = '{1'b1, 1'b0, 4'd1,  8'd240, 8'd4,   4'b0010};
        vt[2]  = '{1'b1, 1'b0, 4'd0,  8'd5,   8'd5,   4'b0000};
        vt[3]  = '{1'b1, 1'b0, 4'd2,  8'd6,   8'd255, 4'b0110};
        vt[4]  = '{1'b1, 1'b0, 4'd0,  8'd127, 8'd127, 4'b0000};
        vt[5]  = '{1'b1, 1'b0, 4'd1,  8'd1,   8'd128, 4'b0101};
        vt[6]  = '{1'b1, 1'b0, 4'd3,  8'h0F,  8'h00,  4'b1000};
        vt[7]  = '{1'b1, 1'b0, 4'd4,  8'hA5,  8'hA5,  4'b0100};
        vt[8]  = '{1'b1, 1'b0, 4'd5,  8'hFF,  8'h5A,  4'b0000};
        vt[9]  = '{1'b1, 1'b0, 4'd6,  8'h33,  8'hA5,  4'b0100};
        vt[10] = '{1'b1, 1'b0, 4'd7,  8'h00,  8'h4A,  4'b0010};
        vt[11] = '{1'b1, 1'b0, 4'd8,  8'h00,  8'h25,  4'b0000};
        vt[12] = '{1'b1, 1'b0, 4'd8,  8'h00,  8'h12,  4'b0010};
        vt[13] = '{1'b1, 1'b0, 4'd12, 8'h77,  8'h12,  4'b0010};
        vt[14] = '{1'b1, 1'b0, 4'd15, 8'h77,  8'h12,  4'b0010};
        vt[15] = '{1'b0, 1'b0, 4'd0,  8'h99,  8'h12,  4'b0010};
        vt[16] = '{1'b1, 1'b0, 4'd0,  8'hFF,  8'hFF,  4'b0100};
        vt[17] = '{1'b0, 1'b1, 4'd0,  8'h00,  8'h00,  4'b1010};
        vt[18] = '{1'b1, 1'b1, 4'd0,  8'd7,   8'd7,   4'b0000};
        vt[19] = '{1'b0, 1'b1, 4'd2,  8'h40,  8'd8,   4'b0000};
        vt[20] = '{1'b1, 1'b0, 4'd0,  8'h7F,  8'h7F,  4'b0000};
        vt[21] = '{1'b0, 1'b1, 4'd0,  8'h00,  8'h80,  4'b0101};
        vt[22] = '{1'b1, 1'b0, 4'd2,  8'h01,  8'h7F,  4'b0001};
        vt[23] = '{1'b1, 1'b0, 4'd2,  8'h80,  8'hFF,  4'b0111};
        vt[24] = '{1'b1, 1'b0, 4'd1,  8'h80,  8'h7F,  4'b0011};

        for (int i = 0; i < 25; i++)
            apply(vt[i].wen, vt[i].inc, vt[i].op, vt[i].b, vt[i].d, vt[i].f,
                  $sformatf("vec%0d", i));

        apply(1'b1, 1'b0, 4'd0, 8'd12, 8'd12, 4'b0000, "pass12");
`ifdef ACC_ALU_N_MUL_EN
        run_multi(4'd9, 8'd13, 8, 8'd156, 4'b0100, 1'b0, "mul12x13");
        apply(1'b1, 1'b0, 4'd0, 8'd20, 8'd20, 4'b0000, "pass20");
        run_multi(4'd9, 8'd20, 8, 8'd144, 4'b0110, 1'b0, "mul20x20");
`else
        apply(1'b1, 1'b0, 4'd9, 8'd13, 8'd12, 4'b0000, "mul_noop");
        seen = 0;
        repeat (10) begin
            if (bus.busy || bus.done) seen = 1;
            @(posedge Clk); #1;
        end
        chk("mul_noop busy_done", 32'(seen), 32'd0);
`endif

        apply(1'b1, 1'b0, 4'd0, 8'h81, 8'h81, 4'b0100, "pass81");
        run_multi(4'd10, 8'd3, 3, 8'h08, 4'b0000, 1'b1, "shln3_inject");
        run_multi(4'd10, 8'd0, 0, 8'h08, 4'b0000, 1'b0, "shln0");
        apply(1'b1, 1'b0, 4'd0, 8'h80, 8'h80, 4'b0100, "pass80");
        run_multi(4'd11, 8'd20, 8, 8'h00, 4'b1010, 1'b0, "shrn20");
        apply(1'b1, 1'b0, 4'd0, 8'h01, 8'h01, 4'b0000, "pass01");
        run_multi(4'd10, 8'd8, 8, 8'h00, 4'b1010, 1'b0, "shln8");

        // Abort an in-flight multi-cycle op with a reset pulse between clock edges.
        apply(1'b1, 1'b0, 4'd0, 8'h5A, 8'h5A, 4'b0000, "pass5a");
`ifdef ACC_ALU_N_MUL_EN
        drive(1'b1, 1'b0, 4'd9, 8'd13);
`else
        drive(1'b1, 1'b0, 4'd10, 8'd5);
`endif
        @(posedge Clk); #1;
        idle();
        chk("abort busy_before", 32'(bus.busy), 32'd1);
        @(posedge Clk); #1;
        #2 RST = 1'b1;
        #1;
        chk("abort dout", 32'(bus.dout), 32'd0);
        chk("abort flags", 32'({bus.Z, bus.N, bus.C, bus.V}), 32'd0);
        chk("abort busy_done", 32'({bus.busy, bus.done}), 32'd0);
        #2 RST = 1'b0;
        seen = 0;
        repeat (12) begin
            @(posedge Clk); #1;
            if (bus.done || bus.busy) seen = 1;
        end
        chk("abort no_done", 32'(seen), 32'd0);
        apply(1'b1, 1'b0, 4'd0, 8'd3, 8'd3, 4'b0000, "pass3_after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
